// File: rtl/time_set_loader.sv
// Byte-serial time-set frame loader: hunts for a 6-byte frame, validates the
// date/time fields and presents them with a one-cycle load or error strobe.
module time_set_loader #(
  parameter int unsigned TIMEOUT_CYC = 1000
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [7:0]  i_data,
  input  logic        i_valid,
  output logic        o_ready,
  output logic [11:0] o_year,
  output logic [3:0]  o_month,
  output logic [7:0]  o_day,
  output logic [7:0]  o_hour,
  output logic [7:0]  o_min,
  output logic        o_load,
  output logic        o_err,
  output logic        o_busy
);

  typedef enum logic [1:0] {StIdle, StRecv, StCheck, StDone} state_e;

  localparam logic [15:0] TimeoutVal = 16'(TIMEOUT_CYC);

  state_e      r_state;
  logic        r_ready;
  logic        r_load;
  logic        r_err;
  logic [2:0]  r_idx;
  logic [15:0] r_gap;
  logic [3:0]  r_sh_yhi;
  logic [7:0]  r_sh_ylo;
  logic [7:0]  r_sh_mon;
  logic [7:0]  r_sh_day;
  logic [7:0]  r_sh_hour;
  logic [7:0]  r_sh_min;
  logic [11:0] r_year;
  logic [3:0]  r_month;
  logic [7:0]  r_day;
  logic [7:0]  r_hour;
  logic [7:0]  r_min;

  logic        w_accept;
  logic [15:0] w_gap_inc;
  logic        w_mon_ok;
  logic        w_day_ok;
  logic        w_hour_ok;
  logic        w_min_ok;
  logic        w_frame_ok;

  function automatic logic bcd_ok(input logic [7:0] v);
    return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9);
  endfunction

  assign w_accept  = i_valid && r_ready;
  assign w_gap_inc = r_gap + 16'd1;

  // With both nibbles proven BCD, plain hex compares give decimal ranges.
  assign w_mon_ok   = (r_sh_mon[7:4] == 4'h0) && (r_sh_mon[3:0] >= 4'd1) &&
                      (r_sh_mon[3:0] <= 4'd12);
  assign w_day_ok   = bcd_ok(r_sh_day) && (r_sh_day >= 8'h01) && (r_sh_day <= 8'h31);
  assign w_hour_ok  = bcd_ok(r_sh_hour) && (r_sh_hour <= 8'h23);
  assign w_min_ok   = bcd_ok(r_sh_min) && (r_sh_min <= 8'h59);
  assign w_frame_ok = w_mon_ok && w_day_ok && w_hour_ok && w_min_ok;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state   <= StIdle;
      r_ready   <= 1'b0;
      r_load    <= 1'b0;
      r_err     <= 1'b0;
      r_idx     <= 3'd0;
      r_gap     <= 16'd0;
      r_sh_yhi  <= 4'd0;
      r_sh_ylo  <= 8'd0;
      r_sh_mon  <= 8'd0;
      r_sh_day  <= 8'd0;
      r_sh_hour <= 8'd0;
      r_sh_min  <= 8'd0;
      r_year    <= 12'd0;
      r_month   <= 4'd1;
      r_day     <= 8'h01;
      r_hour    <= 8'h00;
      r_min     <= 8'h00;
    end else begin
      r_load <= 1'b0;
      r_err  <= 1'b0;
      unique case (r_state)
        StIdle: begin
          r_ready <= 1'b1;
          // Non-sync bytes are silently dropped while hunting.
          if (w_accept && (i_data[7:4] == 4'hA)) begin
            r_sh_yhi <= i_data[3:0];
            r_idx    <= 3'd1;
            r_gap    <= 16'd0;
            r_state  <= StRecv;
          end
        end
        StRecv: begin
          if (w_accept) begin
            r_gap <= 16'd0;
            case (r_idx)
              3'd1:    r_sh_ylo  <= i_data;
              3'd2:    r_sh_mon  <= i_data;
              3'd3:    r_sh_day  <= i_data;
              3'd4:    r_sh_hour <= i_data;
              default: r_sh_min  <= i_data;
            endcase
            if (r_idx == 3'd5) begin
              r_state <= StCheck;
              r_ready <= 1'b0;
            end else begin
              r_idx <= r_idx + 3'd1;
            end
          end else if (w_gap_inc == TimeoutVal) begin
            r_state <= StDone;
            r_ready <= 1'b0;
            r_err   <= 1'b1;
            r_idx   <= 3'd0;
            r_gap   <= 16'd0;
          end else begin
            r_gap <= w_gap_inc;
          end
        end
        StCheck: begin
          r_state <= StDone;
          r_idx   <= 3'd0;
          if (w_frame_ok) begin
            r_year  <= {r_sh_yhi, r_sh_ylo};
            r_month <= r_sh_mon[3:0];
            r_day   <= r_sh_day;
            r_hour  <= r_sh_hour;
            r_min   <= r_sh_min;
            r_load  <= 1'b1;
          end else begin
            r_err <= 1'b1;
          end
        end
        StDone: begin
          r_state <= StIdle;
          r_ready <= 1'b1;
        end
      endcase
    end
  end

  assign o_ready = r_ready;
  assign o_load  = r_load;
  assign o_err   = r_err;
  assign o_busy  = (r_state != StIdle);
  assign o_year  = r_year;
  assign o_month = r_month;
  assign o_day   = r_day;
  assign o_hour  = r_hour;
  assign o_min   = r_min;

endmodule
